alu_cmd_issuer: RTL and testbench
=================================

// Module: alu_cmd_issuer
// PURPOSE
//  Sequential initiator for the combinational 8-bit ALU. Accepts operation
//  commands over a valid/ready port, drives registered operands and opcode to
//  the ALU, then captures the 8-bit result. Returns the result on a valid/ready
//  response port. An internal golden model checks every captured result and
//  flags any mismatch. Sits between the command source (CPU/test sequencer) and the ALU.
// PARAMETERS
//  OPW   3  opcode width (fixed encoding below)
//  DW    4  operand width
//  RW    8  result width
//  CNTW  8  accepted-command counter width
// PORTS
//  clk          in   1     single clock, rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  cmd_valid    in   1     command present
//  cmd_ready    out  1     issuer can accept command
//  cmd_opcode   in   OPW   000 add,001 sub,010 mul,011 and,100 or,101 not(a),110 xor,111 xnor
//  cmd_a        in   DW    operand a
//  cmd_b        in   DW    operand b
//  alu_a        out  DW    registered operand a to ALU
//  alu_b        out  DW    registered operand b to ALU
//  alu_opcode   out  OPW   registered opcode to ALU
//  alu_result   in   RW    combinational ALU result
//  rsp_valid    out  1     response present
//  rsp_ready    in   1     consumer accepts response
//  rsp_data     out  RW    captured ALU result
//  rsp_opcode   out  OPW   opcode that produced rsp_data
//  rsp_mismatch out  1     rsp_data != golden model for this response
//  err_sticky   out  1     set on any mismatch; cleared only by reset
//  cmd_count    out  CNTW  number of accepted commands, wraps 255->0
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; alu_a/alu_b/alu_opcode=0.
//    rsp_valid=0, rsp_data=0, rsp_opcode=0, rsp_mismatch=0, err_sticky=0.
//    cmd_count=0. cmd_ready forced 0 while rst_n=0.
//  - FSM states: IDLE, DRIVE, RESP.
//  - cmd_ready = (IDLE) | (RESP & rsp_ready); combinational from state and rsp_ready.
//  - Accept = cmd_valid & cmd_ready at a rising edge. At that edge, load alu_a/b/opcode
//    and the golden-model operand copies, increment cmd_count, and move to DRIVE.
//  - IDLE: no accept -> stay.
//  - DRIVE (exactly 1 cycle): ALU settles. At the next edge, capture alu_result ->
//    rsp_data, alu_opcode -> rsp_opcode, and the compare -> rsp_mismatch.
//    Set rsp_valid=1 and go to RESP. A mismatch also sets err_sticky.
//  - Latency: cmd accepted at edge k -> rsp_valid high after edge k+1.
//  - RESP: rsp_data/rsp_opcode/rsp_mismatch stable while rsp_valid & !rsp_ready.
//    On rsp_ready & no accept: rsp_valid=0, go to IDLE.
//    On rsp_ready & accept (same edge): retire the response and load the new
//    command -> DRIVE. rsp_valid drops for the DRIVE cycle.
//    Peak throughput is 1 command per 2 cycles.
//  - alu_* outputs hold their last command in IDLE/RESP; no glitching between commands.
//  - Golden model: a,b zero-extended to RW before the op; result is mod 2^RW.
//    add 0..30; sub wraps (3-5=8'hFE); mul 0..225; and/or/xor upper nibble 0.
//    not = ~{4'h0,a} (a=3 -> 8'hFC); xnor = ~({4'h0,a}^{4'h0,b}) (upper nibble F).
//  - cmd_count wraps silently; no overflow flag.
//  - Reset mid-operation: any in-flight command or response is discarded.
//    No response is emitted after reset is released.
// TESTING
//  1. Reset, then cmd add a=4'hF b=4'hF -> rsp_valid 2 edges later;
//     rsp_data=8'h1E, rsp_opcode=000, rsp_mismatch=0, cmd_count=1.
//  2. Walk all 8 opcodes with a=3 b=5 through a correct ALU model
//     -> 08,FE,0F,01,07,FC,06,F9; err_sticky stays 0.
//  3. Hold rsp_ready=0 for 5 cycles on mul a=9 b=7 -> rsp_data=8'h3F held stable,
//     cmd_ready=0 throughout; release -> one handshake only.
//  4. Back-to-back: cmd_valid and rsp_ready held high, 4 commands
//     -> each accepted on the same edge the prior response retires;
//     4 responses in 8 cycles, in order.
//  5. Fault-inject ALU (force alu_result=8'h00 on xor a=A b=5)
//     -> rsp_data=00, rsp_mismatch=1, err_sticky=1 and stays 1 after later good ops.
//  6. Assert rst_n=0 during DRIVE and during RESP -> all outputs return to reset
//     values immediately; 256 accepts from reset -> cmd_count wraps to 0.

Source files
------------

// File: rtl/alu_cmd_issuer_if.sv
// Bus bundle between the command issuer, its command source, the ALU and the response sink.
// The issuer is the master; the surrounding environment (source, ALU, sink) is the slave.
interface alu_cmd_issuer_if;
  localparam int unsigned OPW  = 3;
  localparam int unsigned DW   = 4;
  localparam int unsigned RW   = 8;
  localparam int unsigned CNTW = 8;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [OPW-1:0]  cmd_opcode;
  logic [DW-1:0]   cmd_a;
  logic [DW-1:0]   cmd_b;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [OPW-1:0]  alu_opcode;
  logic [RW-1:0]   alu_result;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [RW-1:0]   rsp_data;
  logic [OPW-1:0]  rsp_opcode;
  logic            rsp_mismatch;
  logic            err_sticky;
  logic [CNTW-1:0] cmd_count;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_opcode,
    output rsp_valid, rsp_data, rsp_opcode, rsp_mismatch, err_sticky, cmd_count
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_opcode,
    input  rsp_valid, rsp_data, rsp_opcode, rsp_mismatch, err_sticky, cmd_count
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Sequential initiator for the 8-bit combinational ALU: registers a command onto the ALU,
// captures the result one cycle later, checks it against a golden model and returns it.
module alu_cmd_issuer (
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_issuer_if.master  bus
);
  localparam int unsigned OPW  = 3;
  localparam int unsigned DW   = 4;
  localparam int unsigned RW   = 8;
  localparam int unsigned CNTW = 8;

  localparam logic [OPW-1:0] OP_ADD  = 3'd0;
  localparam logic [OPW-1:0] OP_SUB  = 3'd1;
  localparam logic [OPW-1:0] OP_MUL  = 3'd2;
  localparam logic [OPW-1:0] OP_AND  = 3'd3;
  localparam logic [OPW-1:0] OP_OR   = 3'd4;
  localparam logic [OPW-1:0] OP_NOT  = 3'd5;
  localparam logic [OPW-1:0] OP_XOR  = 3'd6;
  localparam logic [OPW-1:0] OP_XNOR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_load;
  logic            w_capture;
  logic            w_retire;
  logic            w_cmd_ready_c;
  logic            w_accept;
  logic            w_mismatch;
  logic [RW-1:0]   w_golden;

  logic [DW-1:0]   r_alu_a;
  logic [DW-1:0]   r_alu_b;
  logic [OPW-1:0]  r_alu_opcode;
  logic [DW-1:0]   r_gold_a;
  logic [DW-1:0]   r_gold_b;
  logic [OPW-1:0]  r_gold_opcode;
  logic            r_rsp_valid;
  logic [RW-1:0]   r_rsp_data;
  logic [OPW-1:0]  r_rsp_opcode;
  logic            r_rsp_mismatch;
  logic            r_err_sticky;
  logic [CNTW-1:0] r_cmd_count;

  // Operands are zero-extended to result width; arithmetic wraps modulo 2^RW.
  function automatic logic [RW-1:0] f_golden(input logic [OPW-1:0] op,
                                             input logic [DW-1:0]  a,
                                             input logic [DW-1:0]  b);
    logic [RW-1:0] wa;
    logic [RW-1:0] wb;
    wa = RW'(a);
    wb = RW'(b);
    f_golden = '0;
    case (op)
      OP_ADD:  f_golden = wa + wb;
      OP_SUB:  f_golden = wa - wb;
      OP_MUL:  f_golden = wa * wb;
      OP_AND:  f_golden = wa & wb;
      OP_OR:   f_golden = wa | wb;
      OP_NOT:  f_golden = ~wa;
      OP_XOR:  f_golden = wa ^ wb;
      OP_XNOR: f_golden = ~(wa ^ wb);
      default: f_golden = '0;
    endcase
  endfunction

  // Ready is held low throughout reset so nothing is accepted while the state is forced.
  assign w_cmd_ready_c = rst_n & ((r_state == S_IDLE) | ((r_state == S_RESP) & bus.rsp_ready));
  assign w_accept      = bus.cmd_valid & w_cmd_ready_c;
  assign w_golden      = f_golden(r_gold_opcode, r_gold_a, r_gold_b);
  assign w_mismatch    = (bus.alu_result != w_golden);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_capture   = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_retire = 1'b1;
          if (w_accept) begin
            w_load      = 1'b1;
            w_state_nxt = S_DRIVE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: ALU operand registers, golden copies, response capture and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_opcode   <= '0;
      r_gold_a       <= '0;
      r_gold_b       <= '0;
      r_gold_opcode  <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_rsp_opcode   <= '0;
      r_rsp_mismatch <= 1'b0;
      r_err_sticky   <= 1'b0;
      r_cmd_count    <= '0;
    end else begin
      if (w_load) begin
        r_alu_a       <= bus.cmd_a;
        r_alu_b       <= bus.cmd_b;
        r_alu_opcode  <= bus.cmd_opcode;
        r_gold_a      <= bus.cmd_a;
        r_gold_b      <= bus.cmd_b;
        r_gold_opcode <= bus.cmd_opcode;
        r_cmd_count   <= r_cmd_count + CNTW'(1);
      end
      if (w_capture) begin
        r_rsp_valid    <= 1'b1;
        r_rsp_data     <= bus.alu_result;
        r_rsp_opcode   <= r_alu_opcode;
        r_rsp_mismatch <= w_mismatch;
        if (w_mismatch) r_err_sticky <= 1'b1;
      end else if (w_retire) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready    = w_cmd_ready_c;
  assign bus.alu_a        = r_alu_a;
  assign bus.alu_b        = r_alu_b;
  assign bus.alu_opcode   = r_alu_opcode;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.rsp_opcode   = r_rsp_opcode;
  assign bus.rsp_mismatch = r_rsp_mismatch;
  assign bus.err_sticky   = r_err_sticky;
  assign bus.cmd_count    = r_cmd_count;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed vector table, stall/back-to-back/fault/reset
// sequences, and randomized traffic scored against a queue-based reference model.
module tb_alu_cmd_issuer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_issuer_if u_if ();

  alu_cmd_issuer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  // Reference ALU behaviour written as plain integer arithmetic on the opcode table.
  function automatic int ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b + 256;
      2: r = a * b;
      3: r = a & b;
      4: r = a | b;
      5: r = 255 - a;
      6: r = a ^ b;
      default: r = 255 - (a ^ b);
    endcase
    return r % 256;
  endfunction

  logic fault_en = 1'b0;
  assign u_if.alu_result = fault_en ? 8'h00 :
         8'(ref_alu(int'(u_if.alu_opcode), int'(u_if.alu_a), int'(u_if.alu_b)));

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int hs_count = 0;
  logic [7:0] model_cnt = 8'h00;
  logic       exp_err   = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && u_if.rsp_valid && u_if.rsp_ready) hs_count <= hs_count + 1;
  end

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_ready"},    32'(u_if.cmd_ready),    0);
    chk({tag, "_alu_a"},        32'(u_if.alu_a),        0);
    chk({tag, "_alu_b"},        32'(u_if.alu_b),        0);
    chk({tag, "_alu_opcode"},   32'(u_if.alu_opcode),   0);
    chk({tag, "_rsp_valid"},    32'(u_if.rsp_valid),    0);
    chk({tag, "_rsp_data"},     32'(u_if.rsp_data),     0);
    chk({tag, "_rsp_opcode"},   32'(u_if.rsp_opcode),   0);
    chk({tag, "_rsp_mismatch"}, 32'(u_if.rsp_mismatch), 0);
    chk({tag, "_err_sticky"},   32'(u_if.err_sticky),   0);
    chk({tag, "_cmd_count"},    32'(u_if.cmd_count),    0);
  endtask

  task automatic release_reset();
    step();
    rst_n = 1'b1;
    model_cnt = 8'h00;
    exp_err   = 1'b0;
    step();
  endtask

  // One isolated transaction with an optional response stall of 'hold' cycles.
  task automatic run_one(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] exp, input int hold);
    int g;
    int hs0;
    u_if.cmd_opcode = op;
    u_if.cmd_a      = a;
    u_if.cmd_b      = b;
    u_if.cmd_valid  = 1'b1;
    u_if.rsp_ready  = 1'b0;
    #1;
    g = 0;
    while (!u_if.cmd_ready && g < 20) begin
      step();
      #1;
      g++;
    end
    chk("accept_wait", 32'(g < 20), 1);
    if (g >= 20) begin
      u_if.cmd_valid = 1'b0;
      return;
    end
    step();
    u_if.cmd_valid = 1'b0;
    model_cnt = model_cnt + 8'd1;
    chk("drive_rsp_valid", 32'(u_if.rsp_valid),  0);
    chk("drive_alu_a",     32'(u_if.alu_a),      32'(a));
    chk("drive_alu_b",     32'(u_if.alu_b),      32'(b));
    chk("drive_alu_op",    32'(u_if.alu_opcode), 32'(op));
    chk("drive_cmd_ready", 32'(u_if.cmd_ready),  0);
    chk("cmd_count",       32'(u_if.cmd_count),  32'(model_cnt));
    step();
    chk("rsp_valid",    32'(u_if.rsp_valid),    1);
    chk("rsp_data",     32'(u_if.rsp_data),     32'(exp));
    chk("rsp_opcode",   32'(u_if.rsp_opcode),   32'(op));
    chk("rsp_mismatch", 32'(u_if.rsp_mismatch), 32'(fault_en));
    chk("err_sticky",   32'(u_if.err_sticky),   32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      chk("stall_cmd_ready", 32'(u_if.cmd_ready), 0);
      step();
      chk("stall_valid", 32'(u_if.rsp_valid), 1);
      chk("stall_data",  32'(u_if.rsp_data),  32'(exp));
    end
    hs0 = hs_count;
    u_if.rsp_ready = 1'b1;
    #1;
    chk("resp_cmd_ready", 32'(u_if.cmd_ready), 1);
    step();
    u_if.rsp_ready = 1'b0;
    chk("retire_valid", 32'(u_if.rsp_valid), 0);
    chk("one_handshake", 32'(hs_count), 32'(hs0 + 1));
  endtask

  // Randomized (or saturated) traffic scored against an in-order expectation queue.
  task automatic stream(input int n, input int pv, input int pr, input bit b2b,
                        output int first_acc, output int last_hs);
    exp_t q[$];
    exp_t e;
    int issued;
    int guard;
    bit acc;
    bit hs;
    bit stall;
    logic [7:0] sd;
    logic [2:0] so;
    issued    = 0;
    guard     = 0;
    stall     = 1'b0;
    sd        = 8'h00;
    so        = 3'd0;
    first_acc = -1;
    last_hs   = -1;
    u_if.cmd_valid = 1'b0;
    while ((issued < n || q.size() > 0) && guard < n * 20 + 50) begin
      if (!u_if.cmd_valid && issued < n && $urandom_range(99) < 32'(pv)) begin
        u_if.cmd_opcode = 3'($urandom_range(7));
        u_if.cmd_a      = 4'($urandom_range(15));
        u_if.cmd_b      = 4'($urandom_range(15));
        u_if.cmd_valid  = 1'b1;
      end
      u_if.rsp_ready = ($urandom_range(99) < 32'(pr));
      #1;
      chk("stream_cmd_count", 32'(u_if.cmd_count), 32'(model_cnt));
      if (stall) begin
        chk("hold_valid",  32'(u_if.rsp_valid),  1);
        chk("hold_data",   32'(u_if.rsp_data),   32'(sd));
        chk("hold_opcode", 32'(u_if.rsp_opcode), 32'(so));
      end
      acc   = u_if.cmd_valid && u_if.cmd_ready;
      hs    = u_if.rsp_valid && u_if.rsp_ready;
      stall = u_if.rsp_valid && !u_if.rsp_ready;
      sd    = u_if.rsp_data;
      so    = u_if.rsp_opcode;
      if (hs) begin
        if (q.size() == 0) begin
          chk("spurious_rsp", 1, 0);
        end else begin
          e = q.pop_front();
          chk("stream_data",     32'(u_if.rsp_data),     32'(e.data));
          chk("stream_opcode",   32'(u_if.rsp_opcode),   32'(e.op));
          chk("stream_mismatch", 32'(u_if.rsp_mismatch), 0);
        end
        last_hs = cyc;
      end
      if (b2b && acc && issued > 0) chk("b2b_same_edge", 32'(hs), 1);
      if (acc) begin
        q.push_back('{op: u_if.cmd_opcode,
                      data: 8'(ref_alu(int'(u_if.cmd_opcode), int'(u_if.cmd_a), int'(u_if.cmd_b)))});
        model_cnt = model_cnt + 8'd1;
        issued++;
        if (first_acc < 0) first_acc = cyc;
      end
      step();
      if (acc) u_if.cmd_valid = 1'b0;
      guard++;
    end
    chk("stream_complete", 32'(q.size() == 0 && issued == n), 1);
    u_if.cmd_valid = 1'b0;
    u_if.rsp_ready = 1'b0;
  endtask

  // Assert reset while a command is in DRIVE (depth 1) or its response is in RESP (depth 2).
  task automatic reset_in_flight(input int depth, input string tag);
    u_if.cmd_opcode = 3'd2;
    u_if.cmd_a      = 4'h7;
    u_if.cmd_b      = 4'h6;
    u_if.cmd_valid  = 1'b1;
    u_if.rsp_ready  = 1'b0;
    #1;
    chk({tag, "_pre_ready"}, 32'(u_if.cmd_ready), 1);
    step();
    u_if.cmd_valid = 1'b0;
    if (depth == 2) step();
    chk({tag, "_pre_valid"}, 32'(u_if.rsp_valid), 32'(depth == 2));
    rst_n = 1'b0;
    #1;
    check_reset_vals(tag);
    release_reset();
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_post_valid"}, 32'(u_if.rsp_valid), 0);
      step();
    end
    chk({tag, "_post_ready"}, 32'(u_if.cmd_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[12];
    int fa;
    int lh;
    int h0;

    u_if.cmd_valid  = 1'b0;
    u_if.cmd_opcode = 3'd0;
    u_if.cmd_a      = 4'h0;
    u_if.cmd_b      = 4'h0;
    u_if.rsp_ready  = 1'b0;

    vt[0]  = '{op: 3'd0, a: 4'hF, b: 4'hF, exp: 8'h1E};
    vt[1]  = '{op: 3'd0, a: 4'h3, b: 4'h5, exp: 8'h08};
    vt[2]  = '{op: 3'd1, a: 4'h3, b: 4'h5, exp: 8'hFE};
    vt[3]  = '{op: 3'd2, a: 4'h3, b: 4'h5, exp: 8'h0F};
    vt[4]  = '{op: 3'd3, a: 4'h3, b: 4'h5, exp: 8'h01};
    vt[5]  = '{op: 3'd4, a: 4'h3, b: 4'h5, exp: 8'h07};
    vt[6]  = '{op: 3'd5, a: 4'h3, b: 4'h5, exp: 8'hFC};
    vt[7]  = '{op: 3'd6, a: 4'h3, b: 4'h5, exp: 8'h06};
    vt[8]  = '{op: 3'd7, a: 4'h3, b: 4'h5, exp: 8'hF9};
    vt[9]  = '{op: 3'd1, a: 4'h0, b: 4'hF, exp: 8'hF1};
    vt[10] = '{op: 3'd2, a: 4'hF, b: 4'hF, exp: 8'hE1};
    vt[11] = '{op: 3'd5, a: 4'h0, b: 4'h9, exp: 8'hFF};

    #2;
    check_reset_vals("reset");
    step();
    release_reset();

    for (int i = 0; i < 12; i++) begin
      run_one(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, 0);
    end
    chk("table_err_sticky", 32'(u_if.err_sticky), 0);

    run_one(3'd2, 4'h9, 4'h7, 8'h3F, 5);
    h0 = hs_count;
    step(); step(); step();
    chk("stall_no_extra_hs", 32'(hs_count), 32'(h0));

    stream(4, 100, 100, 1'b1, fa, lh);
    chk("b2b_span_8", 32'(lh - fa), 8);

    stream(40, 70, 60, 1'b0, fa, lh);
    chk("random_err_sticky", 32'(u_if.err_sticky), 0);

    fault_en = 1'b1;
    exp_err  = 1'b1;
    run_one(3'd6, 4'hA, 4'h5, 8'h00, 2);
    fault_en = 1'b0;
    run_one(3'd0, 4'h1, 4'h2, 8'h03, 0);
    run_one(3'd7, 4'h3, 4'h5, 8'hF9, 0);

    reset_in_flight(1, "rst_drive");
    reset_in_flight(2, "rst_resp");

    stream(256, 100, 100, 1'b1, fa, lh);
    chk("count_wrap", 32'(u_if.cmd_count), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
